sysid_verify_ctrl: RTL and testbench

SYSID_VERIFY_CTRL -- requirements
Module: sysid_verify_ctrl

---
 rtl/sysid_verify_ctrl.sv | 122 ++++++++++++
 tb/tb_sysid_verify_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_verify_ctrl.sv
// Reads the sysid ID and timestamp words and checks them against the expected build values.
// Optional re-read on mismatch is compiled in with `define SYSID_VERIFY_RETRY_EN.
//
// state   | meaning
// IDLE    | waiting for start or the post-reset automatic run
// RD_ID   | address 0 on the bus, wait READ_LATENCY cycles, capture id_value
// RD_TS   | address 1 on the bus, wait READ_LATENCY cycles, capture ts_value
// CHECK   | compare both words, then finish or re-read
module sysid_verify_ctrl #(
    parameter logic [31:0] EXPECTED_ID  = 32'd2899645186,
    parameter logic [31:0] EXPECTED_TS  = 32'd1487200517,
    parameter int          READ_LATENCY = 0,
    parameter int          MAX_RETRY    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [1:0]  retry_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD_ID = 2'd1;
    localparam logic [1:0] S_RD_TS = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    localparam logic [2:0] LAT_LAST  = READ_LATENCY[2:0];
    localparam logic [1:0] RETRY_MAX = MAX_RETRY[1:0];

`ifdef SYSID_VERIFY_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    logic [1:0] state;
    logic [2:0] wait_cnt;
    logic       auto_pending;
    logic       words_match;

    assign words_match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            wait_cnt      <= 3'd0;
            auto_pending  <= 1'b1;
            sysid_address <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            id_value      <= 32'd0;
            ts_value      <= 32'd0;
            retry_count   <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || auto_pending) begin
                        state         <= S_RD_ID;
                        wait_cnt      <= 3'd0;
                        auto_pending  <= 1'b0;
                        sysid_address <= 1'b0;
                        busy          <= 1'b1;
                        pass          <= 1'b0;
                        fail          <= 1'b0;
                        retry_count   <= 2'd0;
                    end
                end
                S_RD_ID: begin
                    if (wait_cnt == LAT_LAST) begin
                        id_value      <= sysid_readdata;
                        wait_cnt      <= 3'd0;
                        sysid_address <= 1'b1;
                        state         <= S_RD_TS;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_RD_TS: begin
                    if (wait_cnt == LAT_LAST) begin
                        ts_value      <= sysid_readdata;
                        wait_cnt      <= 3'd0;
                        sysid_address <= 1'b0;
                        state         <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_CHECK: begin
                    if (words_match) begin
                        pass  <= 1'b1;
                        fail  <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (RETRY_EN && (retry_count < RETRY_MAX)) begin
                        // busy stays high and no done: the retry is part of the same run
                        retry_count <= retry_count + 2'd1;
                        state       <= S_RD_ID;
                    end else begin
                        pass  <= 1'b0;
                        fail  <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// Bench for sysid_verify_ctrl: two instances (READ_LATENCY 0 and 2), each with a scripted sysid slave.
// Expected results come from an attempt-level model of the verification run.
module tb_sysid_verify_ctrl;

    localparam logic [31:0] EXP_ID = 32'd2899645186;
    localparam logic [31:0] EXP_TS = 32'd1487200517;
`ifdef SYSID_VERIFY_RETRY_EN
    localparam int RETRY_LIMIT = 3;
`else
    localparam int RETRY_LIMIT = 0;
`endif

    typedef struct {
        logic [3:0][31:0] ids;
        logic [3:0][31:0] tss;
        bit               pass_nr;
        int               rc_nr;
        bit               pass_r;
        int               rc_r;
        string            name;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start [2];
    logic        addr  [2];
    logic        busy  [2];
    logic        done  [2];
    logic        pass  [2];
    logic        fail  [2];
    logic [31:0] rdata [2];
    logic [31:0] idv   [2];
    logic [31:0] tsv   [2];
    logic [1:0]  rc    [2];

    logic [3:0][31:0] id_rsp [2];
    logic [3:0][31:0] ts_rsp [2];
    int   att_cnt  [2] = '{0, 0};
    int   att_base [2] = '{0, 0};
    logic prev_addr [2] = '{1'b0, 1'b0};

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl [8];

    always #5 clock = ~clock;

    sysid_verify_ctrl #(.READ_LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .start(start[0]), .sysid_address(addr[0]),
        .sysid_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail(fail[0]), .id_value(idv[0]), .ts_value(tsv[0]), .retry_count(rc[0]));

    sysid_verify_ctrl #(.READ_LATENCY(2)) dut1 (
        .clock(clock), .reset(reset), .start(start[1]), .sysid_address(addr[1]),
        .sysid_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail(fail[1]), .id_value(idv[1]), .ts_value(tsv[1]), .retry_count(rc[1]));

    // A completed TS read (address falling 1->0) moves the slave to its next scripted response.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            prev_addr[k] <= addr[k];
            if (prev_addr[k] && !addr[k]) att_cnt[k] <= att_cnt[k] + 1;
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            int d;
            logic [1:0] di;
            d = att_cnt[k] - att_base[k];
            if (d > 3) d = 3;
            if (d < 0) d = 0;
            di = d[1:0];
            rdata[k] = addr[k] ? ts_rsp[k][di] : id_rsp[k][di];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] mk(input logic [31:0] a0, input logic [31:0] a1,
                                             input logic [31:0] a2, input logic [31:0] a3);
        logic [3:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    // Attempt k reads ids[k]/tss[k]; the run ends at the first matching attempt or after RETRY_LIMIT re-reads.
    function automatic void model(input logic [3:0][31:0] ids, input logic [3:0][31:0] tss,
                                  output bit p, output int erc, output int natt,
                                  output logic [31:0] eid, output logic [31:0] ets);
        logic [1:0] ix;
        p = 1'b0;
        natt = RETRY_LIMIT + 1;
        for (int k = 0; k <= RETRY_LIMIT; k++) begin
            if (!p && ids[2'(k)] == EXP_ID && tss[2'(k)] == EXP_TS) begin
                p = 1'b1;
                natt = k + 1;
            end
        end
        erc = natt - 1;
        ix = 2'(natt - 1);
        eid = ids[ix];
        ets = tss[ix];
    endfunction

    task automatic run_check(input int i, input bit via_reset, input bit spam,
                             input logic [3:0][31:0] ids, input logic [3:0][31:0] tss,
                             input bit use_tbl, input bit tbl_pass, input int tbl_rc,
                             input string nm);
        bit p, eb, ea;
        int erc, natt, lat, per, dexp, dcycle, ndone, terr, both;
        logic [31:0] eid, ets;
        model(ids, tss, p, erc, natt, eid, ets);
        lat = (i == 0) ? 0 : 2;
        per = 2 * lat + 3;
        dexp = 1 + natt * per;
        dcycle = -1; ndone = 0; terr = 0; both = 0;
        id_rsp[i] = ids;
        ts_rsp[i] = tss;
        @(negedge clock);
        att_base[i] = att_cnt[i];
        if (via_reset) reset = 1'b0;
        else start[i] = 1'b1;
        for (int c = 1; c <= dexp + 3; c++) begin
            @(negedge clock);
            start[i] = spam && (c < dexp);
            if (done[i]) begin
                ndone++;
                if (dcycle < 0) dcycle = c;
            end
            eb = (c < dexp);
            ea = eb && (((c - 1) % per) >= lat + 1) && (((c - 1) % per) <= 2 * lat + 1);
            if (busy[i] !== eb) terr++;
            if (addr[i] !== ea) terr++;
            if (pass[i] && fail[i]) both++;
        end
        start[i] = 1'b0;
        chk({nm, "_done_cycle"}, 64'(dcycle), 64'(dexp));
        chk({nm, "_done_count"}, 64'(ndone), 64'd1);
        chk({nm, "_pass"}, 64'(pass[i]), 64'(p));
        chk({nm, "_fail"}, 64'(fail[i]), 64'(!p));
        chk({nm, "_retry"}, 64'(rc[i]), 64'(erc));
        chk({nm, "_id"}, 64'(idv[i]), 64'(eid));
        chk({nm, "_ts"}, 64'(tsv[i]), 64'(ets));
        chk({nm, "_busy_addr_errs"}, 64'(terr), 64'd0);
        chk({nm, "_pass_and_fail"}, 64'(both), 64'd0);
        if (use_tbl) begin
            chk({nm, "_tbl_pass"}, 64'(pass[i]), 64'(tbl_pass));
            chk({nm, "_tbl_retry"}, 64'(rc[i]), 64'(tbl_rc));
        end
    endtask

    task automatic chk_zero(input int i, input string nm);
        chk({nm, "_flags"}, 64'({busy[i], done[i], pass[i], fail[i], addr[i], rc[i]}), 64'd0);
        chk({nm, "_id"}, 64'(idv[i]), 64'd0);
        chk({nm, "_ts"}, 64'(tsv[i]), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] good_id, good_ts, ri, rt;
        bit found;
        int inst;
        bit sp, tp;
        int trc;

        good_id = mk(EXP_ID, EXP_ID, EXP_ID, EXP_ID);
        good_ts = mk(EXP_TS, EXP_TS, EXP_TS, EXP_TS);
        tbl[0] = '{good_id, good_ts, 1, 0, 1, 0, "all_match"};
        tbl[1] = '{good_id, mk(0, 0, 0, 0), 0, 0, 0, 3, "ts_zero"};
        tbl[2] = '{mk(EXP_ID ^ 1, EXP_ID ^ 1, EXP_ID ^ 1, EXP_ID ^ 1), good_ts, 0, 0, 0, 3, "id_bit0"};
        tbl[3] = '{mk(0, 0, 0, 0), mk('1, '1, '1, '1), 0, 0, 0, 3, "both_wrong"};
        tbl[4] = '{mk(~EXP_ID, EXP_ID ^ 32'h100, EXP_ID, EXP_ID), good_ts, 0, 0, 1, 2, "id_bad_twice"};
        tbl[5] = '{mk(EXP_ID ^ 32'h8000_0000, EXP_ID ^ 32'h8000_0000, EXP_ID ^ 32'h8000_0000,
                      EXP_ID ^ 32'h8000_0000), good_ts, 0, 0, 0, 3, "id_persist"};
        tbl[6] = '{good_id, mk(EXP_TS ^ 32'h1_0000, EXP_TS, EXP_TS, EXP_TS), 0, 0, 1, 1, "ts_bad_once"};
        tbl[7] = '{good_id, mk(EXP_TS ^ 32'h8000_0000, EXP_TS ^ 32'h8000_0000, EXP_TS ^ 32'h8000_0000,
                              EXP_TS ^ 32'h8000_0000), 0, 0, 0, 3, "ts_bit31"};

        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            id_rsp[k] = good_id;
            ts_rsp[k] = good_ts;
        end

        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");

        run_check(0, 1'b1, 1'b0, good_id, good_ts, 1'b0, 1'b0, 0, "auto_run_l0");
        chk("auto_run_l0_id_word", 64'(idv[0]), 64'd2899645186);
        repeat (8) @(negedge clock);

        for (int i = 0; i < 2; i++) begin
            for (int v = 0; v < 8; v++) begin
`ifdef SYSID_VERIFY_RETRY_EN
                tp = tbl[v].pass_r;  trc = tbl[v].rc_r;
`else
                tp = tbl[v].pass_nr; trc = tbl[v].rc_nr;
`endif
                run_check(i, 1'b0, v[0], tbl[v].ids, tbl[v].tss, 1'b1, tp, trc,
                          $sformatf("%s_l%0d", tbl[v].name, 2 * i));
            end
        end

        // start issued in the done cycle must launch a new run
        id_rsp[1] = good_id;
        ts_rsp[1] = good_ts;
        @(negedge clock);
        att_base[1] = att_cnt[1];
        start[1] = 1'b1;
        @(negedge clock);
        start[1] = 1'b0;
        found = 1'b0;
        for (int c = 1; c < 40 && !found; c++) begin
            if (done[1]) found = 1'b1;
            else @(negedge clock);
        end
        chk("chain_first_done", 64'(found), 64'd1);
        start[1] = 1'b1;
        @(negedge clock);
        start[1] = 1'b0;
        chk("start_in_done_busy", 64'(busy[1]), 64'd1);
        found = 1'b0;
        for (int c = 1; c < 40 && !found; c++) begin
            if (done[1]) found = 1'b1;
            else @(negedge clock);
        end
        chk("chain_second_done", 64'(found), 64'd1);
        chk("chain_second_pass", 64'(pass[1]), 64'd1);
        repeat (3) @(negedge clock);

        // reset during RD_TS aborts silently, then the automatic run passes
        id_rsp[0] = good_id;
        ts_rsp[0] = good_ts;
        @(negedge clock);
        att_base[0] = att_cnt[0];
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        @(negedge clock);
        chk("abort_in_rd_ts_addr", 64'(addr[0]), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_no_done", 64'(done[0]), 64'd0);
        chk_zero(0, "abort_zero");
        repeat (2) @(negedge clock);
        chk("abort_still_no_done", 64'(done[0]), 64'd0);
        run_check(0, 1'b1, 1'b0, good_id, good_ts, 1'b0, 1'b0, 0, "after_abort");
        repeat (8) @(negedge clock);

        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 4; k++) begin
                ri[k] = ($urandom_range(0, 2) != 0) ? EXP_ID : (EXP_ID ^ (32'd1 << $urandom_range(0, 31)));
                rt[k] = ($urandom_range(0, 3) != 0) ? EXP_TS : $urandom;
            end
            inst = int'($urandom_range(0, 1));
            sp = 1'($urandom_range(0, 1));
            run_check(inst, 1'b0, sp, ri, rt, 1'b0, 1'b0, 0, $sformatf("rand%0d_l%0d", r, 2 * inst));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
